// File: rtl/box_pkg.sv
// Shared definitions for the pushable-box sprite: screen geometry, sprite
// size, fall-speed ceiling and the motion state encoding. The box display
// stage imports BOX_SIZE from here so both sides agree on the sprite edge.
package box_pkg;

  typedef enum logic [1:0] {
    REST = 2'd0,
    PUSH = 2'd1,
    FALL = 2'd2
  } box_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BOX_SIZE = 25;
  localparam int MAX_FALL = 8;

  // Default spawn point (top-left corner of the sprite).
  localparam int INIT_X = 368;
  localparam int INIT_Y = 131;

  // Coordinate, velocity and floor-gap widths.
  localparam int COORD_W = 10;
  localparam int VEL_W   = 4;
  localparam int GAP_W   = 4;

  // Unsigned minimum in the 11-bit clamp domain.
  function automatic logic [10:0] min_u11(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/box_motion_if.sv
// Per-frame handshake between the box motion controller and its
// surroundings: collision/map results and player pushes come in, the box
// coordinate, state and update strobe go out.
interface box_motion_if;
  import box_pkg::*;

  logic               respawn;
  logic               push_left;
  logic               push_right;
  logic               blocked_left;
  logic               blocked_right;
  logic [GAP_W-1:0]   floor_gap;
  logic [COORD_W-1:0] BoxX;
  logic [COORD_W-1:0] BoxY;
  box_state_t         box_state;
  logic               frame_tick;

  // Environment side: drives requests and collision results, reads position.
  modport master (
    output respawn, push_left, push_right, blocked_left, blocked_right, floor_gap,
    input  BoxX, BoxY, box_state, frame_tick
  );

  // Controller side.
  modport slave (
    input  respawn, push_left, push_right, blocked_left, blocked_right, floor_gap,
    output BoxX, BoxY, box_state, frame_tick
  );

endinterface

// File: rtl/box_motion_frame_tick_sync.sv
// frame_tick_sync: brings an asynchronous frame-rate strobe into the clk
// domain through two flops and turns each rising edge into a one-cycle
// tick. A level held high yields a single tick; reusable by any frame-rate
// controller.
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;

  // Shift the strobe down the synchroniser chain and into the edge register.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
  end

  // Synchroniser and edge-detect flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop takes its neighbour's pre-edge value;
      // blocking here would collapse the chain into a single stage.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

  // Rising edge of the synchronised strobe; both terms come from flops.
  assign tick = sync2_q & ~edge_q;

endmodule

// File: rtl/box_motion.sv
// box_motion: frame-rate position controller for the pushable box sprite.
// Holds the top-left coordinate and, once per frame tick, applies respawn,
// gravity (with a fall-speed ceiling and bottom clamp) or a one-pixel push.
// Collision and map lookups live outside; only their per-frame results are
// consumed here.
module box_motion #(
  parameter int INIT_X   = box_pkg::INIT_X,
  parameter int INIT_Y   = box_pkg::INIT_Y,
  parameter int BOX_SIZE = box_pkg::BOX_SIZE,
  parameter int MAX_FALL = box_pkg::MAX_FALL
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk,
  box_motion_if.slave  bus
);
  import box_pkg::*;

  // Rightmost / lowest legal top-left coordinate, in the 11-bit clamp domain.
  localparam logic [10:0]      X_MAX    = 11'(SCREEN_W - BOX_SIZE);
  localparam logic [10:0]      Y_MAX    = 11'(SCREEN_H - BOX_SIZE);
  localparam logic [VEL_W:0]   FALL_CAP = (VEL_W+1)'(MAX_FALL);

  logic tick;

  logic [COORD_W-1:0] box_x_q, box_x_d;
  logic [COORD_W-1:0] box_y_q, box_y_d;
  logic [VEL_W-1:0]   vel_q,   vel_d;
  box_state_t         state_q, state_d;

  logic [VEL_W:0]     vel_inc;
  logic [VEL_W-1:0]   vel_next;
  logic [10:0]        y_room;
  logic [10:0]        step;
  logic [10:0]        y_next;
  logic               push_l_ok;
  logic               push_r_ok;

  frame_tick_sync u_frame_tick_sync (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .async_in (frame_clk),
    .tick     (tick)
  );

  // Next position, speed and state; only a tick cycle changes anything.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch
    // can leave one unassigned and infer a latch.
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    vel_d     = vel_q;
    state_d   = state_q;

    // Speed after this frame's gravity, saturated at the ceiling.
    vel_inc   = {1'b0, vel_q} + (VEL_W+1)'(1);
    vel_next  = (vel_inc > FALL_CAP) ? FALL_CAP[VEL_W-1:0] : vel_inc[VEL_W-1:0];

    // Distance left to the bottom of the screen.
    y_room    = (Y_MAX > {1'b0, box_y_q}) ? (Y_MAX - {1'b0, box_y_q}) : 11'd0;

    // Fall step: limited by speed, free space below and the screen bottom.
    step      = min_u11(min_u11(11'(vel_next), 11'(bus.floor_gap)), y_room);
    y_next    = {1'b0, box_y_q} + step;

    // A push moves only when it is the sole push and nothing is in the way.
    push_l_ok = bus.push_left && !bus.push_right && !bus.blocked_left &&
                (box_x_q != '0);
    push_r_ok = bus.push_right && !bus.push_left && !bus.blocked_right &&
                ({1'b0, box_x_q} < X_MAX);

    if (tick) begin
      if (bus.respawn) begin
        box_x_d = COORD_W'(INIT_X);
        box_y_d = COORD_W'(INIT_Y);
        vel_d   = '0;
        state_d = REST;
      end else if (bus.floor_gap != '0) begin
        // Airborne: gravity wins and pushes are ignored.
        box_y_d = (y_next > Y_MAX) ? Y_MAX[COORD_W-1:0] : y_next[COORD_W-1:0];
        vel_d   = vel_next;
        state_d = FALL;
      end else begin
        // On the floor: landing clears the speed, then pushes apply.
        vel_d   = '0;
        state_d = REST;
        if (push_l_ok) begin
          box_x_d = box_x_q - COORD_W'(1);
          state_d = PUSH;
        end else if (push_r_ok) begin
          box_x_d = box_x_q + COORD_W'(1);
          state_d = PUSH;
        end
      end
    end
  end

  // Position, speed and state registers; reset returns to the spawn point.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      box_x_q <= COORD_W'(INIT_X);
      box_y_q <= COORD_W'(INIT_Y);
      vel_q   <= '0;
      state_q <= REST;
    end else begin
      box_x_q <= box_x_d;
      box_y_q <= box_y_d;
      vel_q   <= vel_d;
      state_q <= state_d;
    end
  end

  assign bus.BoxX       = box_x_q;
  assign bus.BoxY       = box_y_q;
  assign bus.box_state  = state_q;
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_box_motion.sv
// Directed bench for box_motion: idle frames, pushes, blocking, gravity with
// speed ceiling and bottom clamp, screen edges, respawn and async reset.
module tb_box_motion;
  import box_pkg::*;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic frame_clk = 1'b0;

  int checks = 0;
  int errors = 0;

  int fall_y [5] = '{132, 134, 137, 141, 146};

  box_motion_if bus ();

  box_motion dut (
    .Clk       (clk),
    .Reset_n   (rst_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_box(input string tag, input int x, input int y, input box_state_t st);
    check({tag, "_x"},     32'(bus.BoxX),      x);
    check({tag, "_y"},     32'(bus.BoxY),      y);
    check({tag, "_state"}, 32'(bus.box_state), 32'(st));
  endtask

  task automatic set_in(input bit rsp, input bit pl, input bit pr,
                        input bit bl, input bit br, input int gap);
    bus.respawn       = rsp;
    bus.push_left     = pl;
    bus.push_right    = pr;
    bus.blocked_left  = bl;
    bus.blocked_right = br;
    bus.floor_gap     = 4'(gap);
  endtask

  // One frame: frame_clk held high for 8 cycles must give exactly one tick,
  // high in the 3rd Clk cycle after the rising edge.
  task automatic do_tick(input bit chk_lat);
    int seen  = 0;
    int first = 99;
    @(negedge clk);
    frame_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        seen++;
        if (first == 99) first = i;
      end
    end
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    check("tick_count", seen, 1);
    if (chk_lat) check("tick_latency", first, 1);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_box("reset", 368, 131, REST);
    check("reset_tick", 32'(bus.frame_tick), 0);
    rst_n = 1'b1;

    // Idle frames on the floor.
    for (int i = 0; i < 3; i++) begin
      do_tick(i == 0);
      check_box("idle", 368, 131, REST);
    end

    // Push right five frames, then a wall on the right.
    set_in(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      do_tick(0);
      check_box("push_r", 368 + i, 131, PUSH);
    end
    set_in(0, 0, 1, 0, 1, 0);
    do_tick(0);
    check_box("blocked_r", 373, 131, REST);

    // Free fall with acceleration.
    set_in(0, 0, 0, 0, 0, 15);
    for (int i = 0; i < 5; i++) begin
      do_tick(0);
      check_box("fall", 373, fall_y[i], FALL);
    end
    set_in(0, 0, 0, 0, 0, 3);
    do_tick(0);
    check_box("fall_gap3", 373, 149, FALL);
    set_in(0, 0, 0, 0, 0, 0);
    do_tick(0);
    check_box("land", 373, 149, REST);

    // Speed restarts from zero after landing; push ignored in the air.
    set_in(0, 1, 0, 0, 0, 15);
    do_tick(0);
    check_box("refall", 373, 150, FALL);

    // Speed saturates at MAX_FALL: steps 2..8 then 8,8 -> 150+35+16.
    set_in(0, 0, 0, 0, 0, 15);
    for (int i = 0; i < 9; i++) do_tick(0);
    check_box("max_fall", 373, 201, FALL);
    set_in(0, 0, 0, 0, 0, 0);
    do_tick(0);
    check_box("land2", 373, 201, REST);

    // Both pushes: no motion.
    set_in(0, 1, 1, 0, 0, 0);
    do_tick(0);
    check_box("both_push", 373, 201, REST);

    // Walk to the left screen edge, then push against it.
    set_in(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 373; i++) do_tick(0);
    check_box("to_left", 0, 201, PUSH);
    do_tick(0);
    check_box("left_edge", 0, 201, REST);

    // Walk to the right screen edge, then push against it.
    set_in(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 615; i++) do_tick(0);
    check_box("to_right", 615, 201, PUSH);
    do_tick(0);
    check_box("right_edge", 615, 201, REST);

    // Bottom clamp: 201 -> 237 after 8 frames, +8 per frame to 453,
    // then room 2 -> 455 on frame 36, frames 37..40 stay at 455.
    set_in(0, 0, 0, 0, 0, 15);
    for (int i = 0; i < 40; i++) do_tick(0);
    check_box("bottom", 615, 455, FALL);

    // Respawn during a fall with a push also asserted.
    set_in(1, 1, 0, 0, 0, 15);
    do_tick(0);
    check_box("respawn", 368, 131, REST);
    set_in(0, 0, 0, 0, 0, 15);
    do_tick(0);
    check_box("post_respawn", 368, 132, FALL);
    do_tick(0);
    check_box("pre_rst", 368, 134, FALL);

    // Async reset asserted while a tick is pending, between clock edges.
    @(negedge clk);
    frame_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_box("async_rst", 368, 131, REST);
    check("async_rst_tick", 32'(bus.frame_tick), 0);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First frame after release starts from zero speed.
    do_tick(0);
    check_box("fresh_frame", 368, 132, FALL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
